// File: rtl/robs_pkg.sv
// Shared constants for the Robertson signed multiplier: FSM state codes,
// control-word bit positions and the R-high source mux encodings.
package robs_pkg;

  localparam int C_W = 15;

  localparam int C_LD_Y    = 0;
  localparam int C_LD_CNT  = 1;
  localparam int C_CLR_A   = 2;
  localparam int C_LD_X    = 3;
  localparam int C_SEL_RH  = 4;   // two bits: [5:4]
  localparam int C_SEL_RL  = 6;
  localparam int C_SEL_X   = 7;
  localparam int C_LD_RH   = 8;
  localparam int C_LD_RL   = 9;
  localparam int C_ADD_SUB = 10;
  localparam int C_SHIFT   = 11;
  localparam int C_SR_CAP  = 12;
  localparam int C_CNT_DEC = 13;
  localparam int C_LD_A    = 14;

  localparam logic [1:0] SEL_RH_A   = 2'd0;
  localparam logic [1:0] SEL_RH_SR  = 2'd1;
  localparam logic [1:0] SEL_RH_ALU = 2'd2;

  typedef logic [C_W-1:0] ctrl_t;
  typedef logic [3:0]     state_t;

  localparam state_t S_IDLE   = 4'd0;
  localparam state_t S_LOAD   = 4'd1;
  localparam state_t S_XFER   = 4'd2;
  localparam state_t S_TEST   = 4'd3;
  localparam state_t S_ADD    = 4'd4;
  localparam state_t S_ADDWB  = 4'd5;
  localparam state_t S_SHIFT  = 4'd6;
  localparam state_t S_SHWB   = 4'd7;
  localparam state_t S_COMMIT = 4'd8;
  localparam state_t S_DONE   = 4'd9;

endpackage

// File: rtl/robs_if.sv
// Controller <-> datapath link: request/status handshake plus the control word
// and the two datapath status flags.
interface robs_if;
  import robs_pkg::*;

  logic  start;
  logic  zr;
  logic  zq;
  ctrl_t c;
  logic  busy;
  logic  done;

  modport master (input start, input zr, input zq, output c, output busy, output done);
  modport slave  (input c, output zr, output zq);

endinterface

// File: rtl/robs_datapath.sv
// Robertson multiplier datapath: Y/A/X operand registers, 16-bit R working
// register, registered adder/subtractor, shift staging register and counter.
module robs_datapath
  import robs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic signed [WIDTH-1:0]   multiplicand,
  input  logic signed [WIDTH-1:0]   multiplier,
  robs_if.slave                     bus,
  output logic signed [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] Q_INIT = CNT_W'(WIDTH - 1);

  logic signed [WIDTH-1:0] y_q, y_d;
  logic signed [WIDTH-1:0] a_q, a_d;
  logic signed [WIDTH-1:0] x_q, x_d;
  logic signed [WIDTH-1:0] alu_q, alu_d;
  logic [2*WIDTH-1:0]      r_q, r_d;
  logic [2*WIDTH-1:0]      sr_q, sr_d;
  logic [CNT_W-1:0]        q_q, q_d;
  logic signed [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0]        rh_mux;
  logic [WIDTH-1:0]        rl_mux;

  assign r_hi = r_q[2*WIDTH-1:WIDTH];

  always_comb begin
    y_d = bus.c[C_LD_Y] ? multiplicand : y_q;

    a_d = a_q;
    if (bus.c[C_CLR_A])     a_d = '0;
    else if (bus.c[C_LD_A]) a_d = r_q[2*WIDTH-1:WIDTH];

    x_d = x_q;
    if (bus.c[C_LD_X]) x_d = bus.c[C_SEL_X] ? r_q[WIDTH-1:0] : multiplier;

    case (bus.c[C_SEL_RH +: 2])
      SEL_RH_SR:  rh_mux = sr_q[2*WIDTH-1:WIDTH];
      SEL_RH_ALU: rh_mux = alu_q;
      default:    rh_mux = a_q;
    endcase
    rl_mux = bus.c[C_SEL_RL] ? sr_q[WIDTH-1:0] : x_q;

    r_d = r_q;
    if (bus.c[C_LD_RH]) r_d[2*WIDTH-1:WIDTH] = rh_mux;
    if (bus.c[C_LD_RL]) r_d[WIDTH-1:0]       = rl_mux;

    // Adder result is always registered; the controller waits one cycle (ADDWB) before using it.
    alu_d = bus.c[C_ADD_SUB] ? (r_hi + y_q) : (r_hi - y_q);

    sr_d = sr_q;
    if (bus.c[C_SR_CAP]) sr_d = bus.c[C_SHIFT] ? {r_q[2*WIDTH-1], r_q[2*WIDTH-1:1]} : r_q;

    q_d = q_q;
    if (bus.c[C_LD_CNT])       q_d = Q_INIT;
    else if (bus.c[C_CNT_DEC]) q_d = q_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    y_q   <= y_d;
    a_q   <= a_d;
    x_q   <= x_d;
    alu_q <= alu_d;
    r_q   <= r_d;
    sr_q  <= sr_d;
    q_q   <= q_d;
  end

  assign bus.zr  = ~r_q[0];
  assign bus.zq  = (q_q == '0);
  assign product = {a_q, x_q};

endmodule

// File: rtl/robs_control.sv
// Moore sequencer for the Robertson signed multiplier: one add/subtract-and-shift
// iteration per multiplier bit, control word decoded purely from registered state.
module robs_control
  import robs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic   clk,
  input  logic   reset,
  robs_if.master bus
);

  state_t state_q, state_d;
  logic   last_q, last_d;
  ctrl_t  c_dec;
  logic   busy_dec;
  logic   done_dec;

  // Datapath muxes and the 3-bit iteration counter are sized for 8-bit operands.
  a_width_fixed: assert property (@(posedge clk) WIDTH == 8);

  always_comb begin
    state_d = S_IDLE;
    last_d  = last_q;
    case (state_q)
      S_IDLE:   state_d = bus.start ? S_LOAD : S_IDLE;
      S_LOAD:   state_d = S_XFER;
      S_XFER:   state_d = S_TEST;
      S_TEST: begin
        last_d  = bus.zq;
        // zr high means the bit under test is 0: only odd R takes the add path.
        state_d = bus.zr ? S_SHIFT : S_ADD;
      end
      S_ADD:    state_d = S_ADDWB;
      S_ADDWB:  state_d = S_SHIFT;
      S_SHIFT:  state_d = S_SHWB;
      S_SHWB:   state_d = S_COMMIT;
      S_COMMIT: state_d = last_q ? S_DONE : S_TEST;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    c_dec    = '0;
    busy_dec = 1'b0;
    done_dec = 1'b0;
    case (state_q)
      S_LOAD: begin
        busy_dec          = 1'b1;
        c_dec[C_LD_Y]     = 1'b1;
        c_dec[C_LD_X]     = 1'b1;
        c_dec[C_CLR_A]    = 1'b1;
        c_dec[C_LD_CNT]   = 1'b1;
      end
      S_XFER: begin
        busy_dec                = 1'b1;
        c_dec[C_SEL_RH +: 2]    = SEL_RH_A;
        c_dec[C_LD_RH]          = 1'b1;
        c_dec[C_LD_RL]          = 1'b1;
      end
      S_TEST:   busy_dec = 1'b1;
      S_ADD: begin
        // last mirrors zq for the whole iteration: subtract on the sign bit.
        busy_dec          = 1'b1;
        c_dec[C_ADD_SUB]  = ~last_q;
      end
      S_ADDWB: begin
        busy_dec             = 1'b1;
        c_dec[C_ADD_SUB]     = ~last_q;
        c_dec[C_SEL_RH +: 2] = SEL_RH_ALU;
        c_dec[C_LD_RH]       = 1'b1;
      end
      S_SHIFT: begin
        busy_dec         = 1'b1;
        c_dec[C_SR_CAP]  = 1'b1;
        c_dec[C_SHIFT]   = 1'b1;
      end
      S_SHWB: begin
        busy_dec             = 1'b1;
        c_dec[C_SEL_RH +: 2] = SEL_RH_SR;
        c_dec[C_SEL_RL]      = 1'b1;
        c_dec[C_LD_RH]       = 1'b1;
        c_dec[C_LD_RL]       = 1'b1;
      end
      S_COMMIT: begin
        busy_dec          = 1'b1;
        c_dec[C_LD_A]     = 1'b1;
        c_dec[C_LD_X]     = 1'b1;
        c_dec[C_SEL_X]    = 1'b1;
        c_dec[C_CNT_DEC]  = ~last_q;
      end
      S_DONE:   done_dec = 1'b1;
      default: begin
        c_dec    = '0;
        busy_dec = 1'b0;
        done_dec = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign bus.c    = c_dec;
  assign bus.busy = busy_dec;
  assign bus.done = done_dec;

endmodule

// File: tb/tb_robs_control.sv
// Directed bench for the Robertson multiplier controller driving its datapath.
module tb_robs_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  multiplier;
  logic [7:0]  multiplicand;
  logic [15:0] product;

  int n_cmp = 0;
  int n_bad = 0;

  robs_if bus();

  robs_control #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  robs_datapath #(.WIDTH(8)) u_dp (
    .clk          (clk),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .bus          (bus),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] mr, input logic [7:0] md,
                        input logic [15:0] exp_p, input int exp_cyc);
    int cyc;
    @(negedge clk);
    multiplier   = mr;
    multiplicand = md;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    bus.start = 1'b0;
    chk($sformatf("%s_c_load", tag), 32'(bus.c), 32'h000F);
    chk($sformatf("%s_busy", tag), 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    cyc = 2;
    chk($sformatf("%s_c_xfer", tag), 32'(bus.c), 32'h0300);
    while (bus.done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("%s_done_seen", tag), 32'(bus.done), 32'd1);
    chk($sformatf("%s_latency", tag), 32'(cyc), 32'(exp_cyc));
    chk($sformatf("%s_product", tag), 32'(product), 32'(exp_p));
    chk($sformatf("%s_busy_done", tag), 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    chk($sformatf("%s_done_pulse", tag), 32'(bus.done), 32'd0);
  endtask

  initial begin
    int dones;
    int done_cyc;
    int cyc;

    reset        = 1'b0;
    bus.start    = 1'b0;
    multiplier   = 8'h00;
    multiplicand = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_c", 32'(bus.c), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("m3x5",    8'h03, 8'h05, 16'h000F, 39);
    run_op("mm3x5",   8'hFD, 8'h05, 16'hFFF1, 49);
    run_op("m80xff",  8'h80, 8'hFF, 16'h0080, 37);
    run_op("m0x7f",   8'h00, 8'h7F, 16'h0000, 35);
    run_op("m7xfa",   8'h07, 8'hFA, 16'hFFD6, 41);
    run_op("mffxff",  8'hFF, 8'hFF, 16'h0001, 51);

    // start held high across a whole operation
    @(negedge clk);
    multiplier   = 8'h03;
    multiplicand = 8'h05;
    bus.start    = 1'b1;
    dones = 0;
    done_cyc = 0;
    for (int i = 1; i <= 39; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        dones++;
        done_cyc = i;
      end
    end
    chk("hold_dones", 32'(dones), 32'd1);
    chk("hold_done_cyc", 32'(done_cyc), 32'd39);
    chk("hold_product", 32'(product), 32'h000F);
    @(posedge clk); #1;
    chk("hold_idle_busy", 32'(bus.busy), 32'd0);
    chk("hold_idle_done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    chk("hold_restart_busy", 32'(bus.busy), 32'd1);
    chk("hold_restart_c", 32'(bus.c), 32'h000F);
    bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("hold_second_lat", 32'(cyc), 32'd39);
    chk("hold_second_product", 32'(product), 32'h000F);

    // reset pulled low in cycle 10 of a run
    repeat (2) @(posedge clk);
    @(negedge clk);
    multiplier   = 8'hFD;
    multiplicand = 8'h05;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("midrst_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_c", 32'(bus.c), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    chk("midrst_no_done", 32'(dones), 32'd0);
    run_op("after_rst", 8'hFD, 8'h05, 16'hFFF1, 49);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
